// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage.
// Holds the PC and issues in-order word fetches over a valid/ready request
// channel. Returned instructions wait in a small FIFO and are presented to
// the ID stage together with their PC. An EX redirect flushes the buffer, and
// responses still in flight are discarded while the stage drains.
// Optional build macro: IF_BYPASS_EN. When it is defined, a response that
// arrives while the buffer is empty goes to ID in the same cycle.
module if_fetch #(
   parameter int                INSTR_W    = 32,
   parameter int                WORD_W     = 32,
   parameter logic [WORD_W-1:0] RESET_PC   = {WORD_W{1'b0}},
   parameter int                FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [WORD_W-1:0]  imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data,
   input  logic               redirect_valid,
   input  logic [WORD_W-1:0]  redirect_pc,
   input  logic               id_stall,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [WORD_W-1:0]  id_pc
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013);
   localparam logic [WORD_W-1:0]  PC_STEP   = WORD_W'(32'd4);
   localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W:0]     OCC_LIMIT = (CNT_W+1)'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t              state_r;
   logic [WORD_W-1:0]   fetch_pc_r;
   logic [WORD_W-1:0]   resp_pc_r;
   logic [CNT_W-1:0]    out_r;
   logic [CNT_W-1:0]    count_r;
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [INSTR_W-1:0]  instr_mem_r [FIFO_DEPTH];
   logic [WORD_W-1:0]   pc_mem_r    [FIFO_DEPTH];

   logic                fifo_empty_s;
   logic                resp_ok_s;
   logic                bypass_s;
   logic                bypass_take_s;
   logic                take_s;
   logic                pop_s;
   logic                push_s;
   logic                accept_s;
   logic [CNT_W:0]      occ_s;
   logic [CNT_W-1:0]    out_next_s;

   // Handshake decode, credit check and ID output selection
   always_comb begin
      fifo_empty_s = (count_r == CNT_ZERO);
      // a response with nothing outstanding is a protocol error and is ignored
      resp_ok_s    = imem_resp_valid && (out_r != CNT_ZERO);
`ifdef IF_BYPASS_EN
      bypass_s     = fifo_empty_s && (state_r == ST_RUN) && !redirect_valid && resp_ok_s;
`else
      bypass_s     = 1'b0;
`endif
      id_valid      = !fifo_empty_s || bypass_s;
      take_s        = id_valid && !id_stall;
      pop_s         = !fifo_empty_s && !id_stall;
      bypass_take_s = bypass_s && !id_stall;
      push_s        = (state_r == ST_RUN) && !redirect_valid && resp_ok_s && !bypass_take_s;

      // a head leaving this cycle frees its slot before any new response can land
      occ_s = {1'b0, count_r} + {1'b0, out_r} - {{CNT_W{1'b0}}, take_s};
      imem_req_valid = !rst && (state_r == ST_RUN) && (occ_s < OCC_LIMIT);
      imem_req_addr  = fetch_pc_r;
      accept_s       = imem_req_valid && imem_req_ready;
      out_next_s     = out_r + {{PTR_W{1'b0}}, accept_s} - {{PTR_W{1'b0}}, resp_ok_s};

      if (!fifo_empty_s) begin
         id_instr = instr_mem_r[rd_ptr_r];
         id_pc    = pc_mem_r[rd_ptr_r];
      end else if (bypass_s) begin
         id_instr = imem_resp_data;
         id_pc    = resp_pc_r;
      end else begin
         id_instr = NOP_INSTR;
         id_pc    = resp_pc_r;
      end
   end

   // RUN/DRAIN control, PC tracking and outstanding-request count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_RUN;
         fetch_pc_r <= RESET_PC;
         resp_pc_r  <= RESET_PC;
         out_r      <= CNT_ZERO;
      end else begin
         out_r <= out_next_s;
         case (state_r)
            ST_RUN: begin
               if (redirect_valid) begin
                  fetch_pc_r <= redirect_pc;
                  resp_pc_r  <= redirect_pc;
                  // anything still in flight belongs to the old path
                  state_r    <= (out_next_s != CNT_ZERO) ? ST_DRAIN : ST_RUN;
               end else begin
                  if (accept_s) begin
                     fetch_pc_r <= fetch_pc_r + PC_STEP;
                  end
                  if (resp_ok_s) begin
                     resp_pc_r <= resp_pc_r + PC_STEP;
                  end
                  state_r <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (redirect_valid) begin
                  fetch_pc_r <= redirect_pc;
                  resp_pc_r  <= redirect_pc;
               end
               state_r <= (out_next_s == CNT_ZERO) ? ST_RUN : ST_DRAIN;
            end
            default: begin
               state_r <= ST_RUN;
            end
         endcase
      end
   end

   // Buffer pointers and occupancy; a redirect empties the buffer outright
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= CNT_ZERO;
      end else if (redirect_valid) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         count_r <= count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
      end
   end

   // Buffer storage; contents are only meaningful below count_r
   always_ff @(posedge clk) begin
      if (push_s) begin
         instr_mem_r[wr_ptr_r] <= imem_resp_data;
         pc_mem_r[wr_ptr_r]    <= resp_pc_r;
      end
   end

`ifndef SYNTHESIS
   // Flag a memory response that has no matching request
   always @(posedge clk) begin
      if (!rst && imem_resp_valid && (out_r == CNT_ZERO)) begin
         $display("if_fetch: unexpected imem response with nothing outstanding at %0t", $time);
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and random stimulus for if_fetch, checked against a
// queue-based reference of the fetch stream (requests in flight, buffered
// instructions, expected next address).
module tb_if_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_stall = 1'b0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   if_fetch dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_stall(id_stall),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } req_t;

   req_t        pend[$];     // requests accepted by memory, in order
   logic [31:0] bufq[$];     // PCs that should be waiting for ID, in order
   logic [31:0] exp_req_addr;
   int          cyc;
   int          lat = 1;
   int          first_valid_cyc;
   int          checks = 0;
   int          errors = 0;
   logic        last_valid, last_req;
   logic [31:0] last_pc, last_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a >> 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; redirect_valid = 1'b0; id_stall = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_id_valid", id_valid, 1'b0);
      chk("rst_id_instr", id_instr, NOP);
      chk("rst_id_pc", id_pc, 32'h0);
      pend.delete(); bufq.delete();
      exp_req_addr = 32'h0; cyc = 0; first_valid_cyc = -1;
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst_hold_id_valid", id_valid, 1'b0);
   endtask

   // one clock cycle: drive inputs, check outputs against the model, advance model
   task automatic step(input bit rdy, input bit stl, input bit rdr, input logic [31:0] tgt);
      bit   exp_valid, pop, draining, exp_req;
      req_t e;
      @(negedge clk);
      rst = 1'b0;
      imem_req_ready = rdy; id_stall = stl; redirect_valid = rdr; redirect_pc = tgt;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom();
      end
      #1;
      exp_valid = (bufq.size() > 0);
      pop       = exp_valid && !stl;
      draining  = (pend.size() > 0) && pend[0].stale;
      exp_req   = !draining && ((bufq.size() + pend.size() - int'(pop)) < 2);
      chk("req_valid", imem_req_valid, exp_req);
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req_addr);
      chk("id_valid", id_valid, exp_valid);
      if (exp_valid) begin
         chk("id_pc", id_pc, bufq[0]);
         chk("id_instr", id_instr, mem_word(bufq[0]));
      end else begin
         chk("id_nop", id_instr, NOP);
      end
      last_valid = id_valid; last_pc = id_pc; last_instr = id_instr; last_req = imem_req_valid;
      if (first_valid_cyc < 0 && id_valid) first_valid_cyc = cyc;
      // model update for the coming edge
      if (pop && !rdr) void'(bufq.pop_front());
      if (imem_resp_valid) begin
         e = pend.pop_front();
         if (!e.stale && !rdr) bufq.push_back(e.addr);
      end
      if (imem_req_valid && rdy) begin
         pend.push_back('{addr: exp_req_addr, due: cyc + lat, stale: 1'b0});
         exp_req_addr = exp_req_addr + 32'd4;
      end
      if (rdr) begin
         bufq.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         exp_req_addr = tgt;
      end
      cyc++;
   endtask

   initial begin
      bit          found;
      logic [31:0] tgt;
      do_reset();

      // streaming from reset with a 3-cycle stall while PC 8 is at ID
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, (i >= 4 && i <= 6), 1'b0, 32'h0);
         if (i == 6) begin
            chk("stall_hold_pc", last_pc, 32'h8);
            chk("stall_hold_instr", last_instr, 32'h2);
            chk("stall_no_req", last_req, 1'b0);
         end
      end
      chk("first_valid_cycle", 32'(first_valid_cyc), 32'd2);

      // memory not ready for 5 cycles: buffer drains to NOP
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("starve_valid", last_valid, 1'b0);
      chk("starve_nop", last_instr, NOP);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

      // redirect to 0x100 with two requests in flight at latency 3
      lat = 3;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!found && pend.size() == 2) begin
            step(1'b1, 1'b0, 1'b1, 32'h100);
            found = 1'b1;
         end else begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
         end
         if (found) break;
      end
      chk("redir_setup", found, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         if (last_valid) break;
      end
      chk("redir_target", last_pc, 32'h100);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("redir_next", last_pc, 32'h104);

      // redirect coinciding with a response and an ID pop
      lat = 1;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!found && bufq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc && !pend[0].stale) begin
            step(1'b1, 1'b0, 1'b1, 32'h2000);
            found = 1'b1;
         end else begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
         end
         if (found) break;
      end
      chk("same_setup", found, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("same_empty", last_valid, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         if (last_valid) break;
      end
      chk("same_target", last_pc, 32'h2000);

      // address wrap at the top of the space
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

      // random traffic, a mid-run reset, more random traffic
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 300; i++) begin
            lat = $urandom_range(1, 3);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 19) == 0), tgt);
         end
         if (r == 0) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
